mdu_multicycle: RTL and testbench

- Parametrised iterative multiply/divide unit implementing the RV32M/RV64M operations for the multicycle core.
- Sits beside the ALU in the datapath: the controller pulses start with the decoded funct3 and holds the execute state until done.
- The result is then routed through the ALU-out path into the register file write-back.
- Processes one operand bit per cycle with an internal start/busy/done handshake.

---
 rtl/mdu_multicycle.sv | 140 ++++++++++++++
 tb/tb_mdu_multicycle.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/mdu_multicycle.sv
// Iterative RV32M/RV64M multiply/divide unit, one operand bit per cycle; define MDU_EARLY_OUT_EN for zero/corner early-out.
// Latency XLEN+1 cycles from start to done (1 cycle on early-out); start while busy is dropped, nothing is queued.
module mdu_multicycle #(
  parameter int XLEN = 32,
  parameter int CNTW = $clog2(XLEN) + 1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] srcA,
  input  logic [XLEN-1:0] srcB,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] CALC = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]        state;
  logic [CNTW-1:0]   cnt;
  logic [2:0]        op;
  logic              sa, sb, dz, ov;
  logic [XLEN-1:0]   araw;
  logic [XLEN-1:0]   opd;
  logic [2*XLEN-1:0] acc, acc_nxt;

  logic              a_sgn, b_sgn, dz_in, ov_in, early;
  logic [XLEN-1:0]   a_mag, b_mag;
  logic [XLEN:0]     msum, trial;

  // Sign restoration and RISC-V corner overrides, shared by the normal and early-out paths.
  function automatic logic [XLEN-1:0] finalize(
    input logic [2:0]        f,
    input logic [2*XLEN-1:0] a,
    input logic              s_a,
    input logic              s_b,
    input logic              d_z,
    input logic              o_v,
    input logic [XLEN-1:0]   orig_a
  );
    logic [2*XLEN-1:0] prod;
    logic [XLEN-1:0]   q, r, res;
    prod = (s_a ^ s_b) ? -a : a;
    q    = (s_a ^ s_b) ? -a[XLEN-1:0] : a[XLEN-1:0];
    r    = s_a ? -a[2*XLEN-1:XLEN] : a[2*XLEN-1:XLEN];
    case (f)
      3'd0:          res = prod[XLEN-1:0];
      3'd1, 3'd2,
      3'd3:          res = prod[2*XLEN-1:XLEN];
      3'd4, 3'd5:    res = d_z ? '1 : (o_v ? orig_a : q);
      default:       res = d_z ? orig_a : (o_v ? '0 : r);
    endcase
    return res;
  endfunction

  always_comb begin
    a_sgn = srcA[XLEN-1] & (funct3 == 3'd1 || funct3 == 3'd2 || funct3 == 3'd4 || funct3 == 3'd6);
    b_sgn = srcB[XLEN-1] & (funct3 == 3'd1 || funct3 == 3'd4 || funct3 == 3'd6);
    a_mag = a_sgn ? -srcA : srcA;
    b_mag = b_sgn ? -srcB : srcB;
    dz_in = (srcB == '0);
    ov_in = (funct3 == 3'd4 || funct3 == 3'd6) &&
            (srcA == {1'b1, {(XLEN-1){1'b0}}}) && (srcB == '1);
  end

`ifdef MDU_EARLY_OUT_EN
  assign early = funct3[2] ? (dz_in | ov_in) : (srcA == '0 || srcB == '0);
`else
  assign early = 1'b0;
`endif

  // Multiply: acc = {partial product, remaining multiplier}. Divide: acc = {remainder, quotient}.
  always_comb begin
    msum  = {1'b0, acc[2*XLEN-1:XLEN]} + ({1'b0, opd} & {(XLEN+1){acc[0]}});
    trial = acc[2*XLEN-1:XLEN-1] - {1'b0, opd};
    if (op[2])
      acc_nxt = trial[XLEN] ? {acc[2*XLEN-2:0], 1'b0}
                            : {trial[XLEN-1:0], acc[XLEN-2:0], 1'b1};
    else
      acc_nxt = {msum, acc[XLEN-1:1]};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= IDLE;
      cnt    <= '0;
      op     <= '0;
      sa     <= 1'b0;
      sb     <= 1'b0;
      dz     <= 1'b0;
      ov     <= 1'b0;
      araw   <= '0;
      opd    <= '0;
      acc    <= '0;
      result <= '0;
    end else begin
      case (state)
        IDLE: if (start) begin
          op   <= funct3;
          sa   <= a_sgn;
          sb   <= b_sgn;
          dz   <= dz_in;
          ov   <= ov_in;
          araw <= srcA;
          cnt  <= CNTW'(XLEN);
          if (funct3[2]) begin
            acc <= {{XLEN{1'b0}}, a_mag};
            opd <= b_mag;
          end else begin
            acc <= {{XLEN{1'b0}}, b_mag};
            opd <= a_mag;
          end
          if (early) begin
            state  <= DONE;
            result <= finalize(funct3, '0, a_sgn, b_sgn, dz_in, ov_in, srcA);
          end else begin
            state <= CALC;
          end
        end
        CALC: begin
          acc <= acc_nxt;
          cnt <= cnt - 1'b1;
          if (cnt == CNTW'(1)) begin
            state  <= DONE;
            result <= finalize(op, acc_nxt, sa, sb, dz, ov, araw);
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign busy = (state != IDLE);
  assign done = (state == DONE);

endmodule

// File: tb/tb_mdu_multicycle.sv
// Bench for mdu_multicycle: directed vector table, random ops against a 64-bit arithmetic model, handshake/reset sequences.
module tb_mdu_multicycle;

  logic        clk;
  logic        reset;
  logic        start;
  logic [2:0]  funct3;
  logic [31:0] srcA, srcB;
  logic        busy, done;
  logic [31:0] result;

  int n_cmp  = 0;
  int n_fail = 0;

  mdu_multicycle #(.XLEN(32)) dut (
    .clk(clk), .reset(reset), .start(start), .funct3(funct3),
    .srcA(srcA), .srcB(srcB), .busy(busy), .done(done), .result(result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  f;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
  } vec_t;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] ref_res(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    longint            sa_l, sb_l;
    longint unsigned   ua, ub;
    logic [63:0]       p;
    logic [31:0]       r;
    sa_l = $signed(a);
    sb_l = $signed(b);
    ua = {32'd0, a};
    ub = {32'd0, b};
    r = '0;
    case (f)
      3'd0: begin p = ua * ub;       r = p[31:0];  end
      3'd1: begin p = sa_l * sb_l;   r = p[63:32]; end
      3'd2: begin p = sa_l * longint'(ub); r = p[63:32]; end
      3'd3: begin p = ua * ub;       r = p[63:32]; end
      3'd4: begin
        if (b == 0) r = 32'hFFFF_FFFF;
        else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) r = a;
        else begin p = sa_l / sb_l; r = p[31:0]; end
      end
      3'd5: begin
        if (b == 0) r = 32'hFFFF_FFFF;
        else begin p = ua / ub; r = p[31:0]; end
      end
      3'd6: begin
        if (b == 0) r = a;
        else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) r = 32'd0;
        else begin p = sa_l % sb_l; r = p[31:0]; end
      end
      default: begin
        if (b == 0) r = a;
        else begin p = ua % ub; r = p[31:0]; end
      end
    endcase
    return r;
  endfunction

  function automatic int exp_lat(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
`ifdef MDU_EARLY_OUT_EN
    if (f[2]) begin
      if (b == 0) return 1;
      if ((f == 3'd4 || f == 3'd6) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
    end else if (a == 0 || b == 0) begin
      return 1;
    end
`endif
    return 33;
  endfunction

  // Issues one op and counts rising edges from the accepting edge until done is seen.
  task automatic run_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                        input int inj_at, output logic [31:0] r, output int lat, output int busy_lo);
    @(negedge clk);
    start = 1'b1; funct3 = f; srcA = a; srcB = b;
    @(posedge clk);
    lat = 1;
    busy_lo = 0;
    while (lat < 200) begin
      @(negedge clk);
      if (lat == inj_at) begin
        start = 1'b1; funct3 = ~f; srcA = ~a; srcB = b + 32'd1;
      end else begin
        start = 1'b0;
      end
      if (done) break;
      if (!busy) busy_lo++;
      @(posedge clk);
      lat++;
    end
    start = 1'b0;
    r = result;
  endtask

  vec_t        vecs[16];
  logic [31:0] r, held;
  int          lat, blo, ndone;
  logic [2:0]  f;
  logic [31:0] a, b;

  initial begin
    vecs[0]  = '{3'd0, 32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB};
    vecs[1]  = '{3'd1, 32'h8000_0000,  32'hFFFF_FFFF, 32'h0000_0000};
    vecs[2]  = '{3'd2, 32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000};
    vecs[3]  = '{3'd3, 32'h8000_0000,  32'hFFFF_FFFF, 32'h7FFF_FFFF};
    vecs[4]  = '{3'd4, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFD};
    vecs[5]  = '{3'd6, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFF};
    vecs[6]  = '{3'd5, 32'd100,        32'd7,         32'd14};
    vecs[7]  = '{3'd7, 32'd100,        32'd7,         32'd2};
    vecs[8]  = '{3'd4, 32'h1234_5678,  32'd0,         32'hFFFF_FFFF};
    vecs[9]  = '{3'd6, 32'h1234_5678,  32'd0,         32'h1234_5678};
    vecs[10] = '{3'd5, 32'h1234_5678,  32'd0,         32'hFFFF_FFFF};
    vecs[11] = '{3'd7, 32'h1234_5678,  32'd0,         32'h1234_5678};
    vecs[12] = '{3'd4, 32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000};
    vecs[13] = '{3'd6, 32'h8000_0000,  32'hFFFF_FFFF, 32'h0000_0000};
    vecs[14] = '{3'd0, 32'd12345,      32'd0,         32'd0};
    vecs[15] = '{3'd1, 32'hFFFF_FFFE,  32'h0000_0003, 32'hFFFF_FFFF};

    reset = 1'b1; start = 1'b0; funct3 = 3'd0; srcA = '0; srcB = '0;
    @(negedge clk);
    @(negedge clk);
    check("reset_busy", {63'd0, busy}, 64'd0);
    check("reset_done", {63'd0, done}, 64'd0);
    check("reset_result", {32'd0, result}, 64'd0);
    reset = 1'b0;

    for (int i = 0; i < 16; i++) begin
      run_op(vecs[i].f, vecs[i].a, vecs[i].b, 0, r, lat, blo);
      check($sformatf("vec%0d_result", i), {32'd0, r}, {32'd0, vecs[i].exp});
      check($sformatf("vec%0d_latency", i), 64'(lat), 64'(exp_lat(vecs[i].f, vecs[i].a, vecs[i].b)));
      check($sformatf("vec%0d_busy_gap", i), 64'(blo), 64'd0);
    end

    // done is a single-cycle pulse and result holds afterwards.
    held = result;
    @(negedge clk);
    check("done_pulse_width", {63'd0, done}, 64'd0);
    check("idle_busy", {63'd0, busy}, 64'd0);
    repeat (3) @(negedge clk);
    check("result_hold", {32'd0, result}, {32'd0, held});

    for (int i = 0; i < 48; i++) begin
      f = 3'($urandom_range(0, 7));
      a = $urandom;
      b = $urandom;
      case ($urandom_range(0, 7))
        0: b = 32'd0;
        1: a = 32'd0;
        2: b = $urandom_range(1, 20);
        3: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
        default: ;
      endcase
      run_op(f, a, b, 0, r, lat, blo);
      check($sformatf("rnd%0d_f%0d_result", i, f), {32'd0, r}, {32'd0, ref_res(f, a, b)});
      check($sformatf("rnd%0d_latency", i), 64'(lat), 64'(exp_lat(f, a, b)));
    end

    // A second start during CALC with different operands must be dropped.
    run_op(3'd0, 32'd7, 32'hFFFF_FFFD, 5, r, lat, blo);
    check("busy_start_result", {32'd0, r}, 64'h0000_0000_FFFF_FFEB);
    check("busy_start_latency", 64'(lat), 64'd33);
    ndone = 0;
    repeat (40) begin
      @(negedge clk);
      if (done) ndone++;
    end
    check("busy_start_no_second_op", 64'(ndone), 64'd0);

    // Reset in the middle of CALC aborts the op.
    @(negedge clk);
    start = 1'b1; funct3 = 3'd5; srcA = 32'd100; srcB = 32'd7;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    reset = 1'b1;
    #1;
    check("abort_busy", {63'd0, busy}, 64'd0);
    check("abort_result", {32'd0, result}, 64'd0);
    check("abort_done", {63'd0, done}, 64'd0);
    @(negedge clk);
    reset = 1'b0;
    ndone = 0;
    repeat (40) begin
      @(negedge clk);
      if (done || busy) ndone++;
    end
    check("abort_no_done", 64'(ndone), 64'd0);

    run_op(3'd5, 32'd100, 32'd7, 0, r, lat, blo);
    check("post_abort_result", {32'd0, r}, 64'd14);
    check("post_abort_latency", 64'(lat), 64'd33);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
